// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer for the RISKY RV32I core: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and decodes the shared-ALU datapath selects per state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       alu_force_add,
  output logic       alu_sub,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StStart  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  state_e state_q, state_d;
  logic   legal_op;
  logic   br_taken;
  logic   br_bad_f3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StStart;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    legal_op = 1'b0;
    unique case (opcode)
      OpR, OpImm, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui, OpAuipc: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  // funct3 010/011 are not defined branch conditions.
  assign br_bad_f3 = (funct3[2:1] == 2'b01);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    ir_write      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    alu_a_sel     = 2'b00;
    alu_b_sel     = 1'b0;
    alu_force_add = 1'b0;
    alu_sub       = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    trap          = 1'b0;

    case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: state_d = legal_op ? StExec : StTrap;
      StExec: begin
        case (opcode)
          OpR: begin
            alu_sub = funct7[5] | funct3[1];
            state_d = StWb;
          end
          OpImm: begin
            alu_b_sel = 1'b1;
            alu_sub   = funct3[1];
            state_d   = StWb;
          end
          OpLoad, OpStore: begin
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            state_d       = StMem;
          end
          OpBranch: begin
            // ALU only produces the compare flags; the target comes from old_pc+imm.
            alu_sub = 1'b1;
            pc_sel  = 1'b1;
            if (br_bad_f3) begin
              state_d = StTrap;
            end else begin
              pc_write = br_taken;
              state_d  = StFetch;
            end
          end
          OpJal, OpJalr: begin
            alu_a_sel     = (opcode == OpJal) ? 2'b01 : 2'b00;
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            pc_sel        = 1'b1;
            pc_write      = 1'b1;
            state_d       = StWb;
          end
          OpLui, OpAuipc: begin
            alu_a_sel     = (opcode == OpLui) ? 2'b10 : 2'b01;
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            state_d       = StWb;
          end
          default: state_d = StTrap;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OpStore);
        if (mem_ready) begin
          state_d = (opcode == OpStore) ? StFetch : StWb;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        if (opcode == OpLoad) begin
          wb_sel = 2'b01;
        end else if (opcode == OpJal || opcode == OpJalr) begin
          wb_sel = 2'b10;
        end
        state_d = StFetch;
      end
      StTrap: begin
        trap    = 1'b1;
        state_d = StTrap;
      end
      default: state_d = StStart;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: per-opcode state walk and EXEC decode,
// plus hand-written memory-wait, trap and reset-during-handshake sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       br_eq, br_lt, br_ltu, mem_ready;
  logic       pc_write, pc_sel, ir_write, mem_req, mem_we;
  logic [1:0] alu_a_sel;
  logic       alu_b_sel, alu_force_add, alu_sub, reg_write;
  logic [1:0] wb_sel;
  logic       trap;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write), .mem_req(mem_req),
    .mem_we(mem_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_force_add(alu_force_add), .alu_sub(alu_sub), .reg_write(reg_write),
    .wb_sel(wb_sel), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] SStart = 3'd0, SFetch = 3'd1, SDecode = 3'd2, SExec = 3'd3;
  localparam logic [2:0] SMem = 3'd4, SWb = 3'd5, STrap = 3'd6;

  // ex = {pc_write, pc_sel, alu_a_sel[1:0], alu_b_sel, alu_force_add, alu_sub} in EXEC
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] flags;  // {eq, lt, ltu}
    logic [6:0] ex;
    logic [2:0] nxt;
    logic       we;
    logic [1:0] wb;
  } vec_t;

  localparam int NVec = 19;
  vec_t tbl [NVec];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] fl);
    opcode = op; funct3 = f3; funct7 = f7;
    {br_eq, br_lt, br_ltu} = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset state", 32'(state), 32'(SStart));
    chk("reset outputs", 32'({pc_write, pc_sel, ir_write, mem_req, mem_we, alu_a_sel,
        alu_b_sel, alu_force_add, alu_sub, reg_write, wb_sel, trap}), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    #1;
    chk("first state after reset", 32'(state), 32'(SFetch));
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH of the next instruction.
  task automatic run_vec(input int i, input vec_t v);
    set_instr(v.op, v.f3, v.f7, v.flags);
    mem_ready = 1'b1;
    #1;
    chk($sformatf("v%0d fetch enables", i), 32'({state, mem_req, mem_we, ir_write, pc_write,
        pc_sel}), 32'({SFetch, 5'b10110}));
    step(); #1;
    chk($sformatf("v%0d decode", i), 32'({state, pc_write, ir_write, mem_req, reg_write,
        alu_sub}), 32'({SDecode, 5'b00000}));
    step(); #1;
    chk($sformatf("v%0d exec state", i), 32'(state), 32'(SExec));
    chk($sformatf("v%0d exec decode", i), 32'({pc_write, pc_sel, alu_a_sel, alu_b_sel,
        alu_force_add, alu_sub}), 32'(v.ex));
    step(); #1;
    chk($sformatf("v%0d after exec", i), 32'(state), 32'(v.nxt));
    if (state == SMem) begin
      chk($sformatf("v%0d mem req/we", i), 32'({mem_req, mem_we}), 32'({1'b1, v.we}));
      step(); #1;
      chk($sformatf("v%0d after mem", i), 32'(state), 32'(v.we ? SFetch : SWb));
    end
    if (state == SWb) begin
      chk($sformatf("v%0d wb", i), 32'({reg_write, wb_sel, alu_sub}), 32'({1'b1, v.wb, 1'b0}));
      step(); #1;
    end
    chk($sformatf("v%0d back to fetch", i), 32'(state), 32'(SFetch));
  endtask

  initial begin
    int cyc;
    //            op          f3      f7          fl      ex          nxt     we    wb
    tbl[0]  = '{7'b0110011, 3'b000, 7'b0000000, 3'b000, 7'b0000000, SWb,   1'b0, 2'b00}; // ADD
    tbl[1]  = '{7'b0110011, 3'b000, 7'b0100000, 3'b000, 7'b0000001, SWb,   1'b0, 2'b00}; // SUB
    tbl[2]  = '{7'b0110011, 3'b010, 7'b0000000, 3'b000, 7'b0000001, SWb,   1'b0, 2'b00}; // SLT
    tbl[3]  = '{7'b0010011, 3'b010, 7'b0000000, 3'b000, 7'b0000101, SWb,   1'b0, 2'b00}; // SLTI
    tbl[4]  = '{7'b0010011, 3'b000, 7'b0000000, 3'b000, 7'b0000100, SWb,   1'b0, 2'b00}; // ADDI
    tbl[5]  = '{7'b0010011, 3'b100, 7'b0000000, 3'b000, 7'b0000100, SWb,   1'b0, 2'b00}; // XORI
    tbl[6]  = '{7'b0000011, 3'b010, 7'b0000000, 3'b000, 7'b0000110, SMem,  1'b0, 2'b01}; // LW
    tbl[7]  = '{7'b0100011, 3'b010, 7'b0000000, 3'b000, 7'b0000110, SMem,  1'b1, 2'b00}; // SW
    tbl[8]  = '{7'b1100011, 3'b000, 7'b0000000, 3'b100, 7'b1100001, SFetch, 1'b0, 2'b00}; // BEQ t
    tbl[9]  = '{7'b1100011, 3'b000, 7'b0000000, 3'b011, 7'b0100001, SFetch, 1'b0, 2'b00}; // BEQ n
    tbl[10] = '{7'b1100011, 3'b001, 7'b0000000, 3'b000, 7'b1100001, SFetch, 1'b0, 2'b00}; // BNE t
    tbl[11] = '{7'b1100011, 3'b100, 7'b0000000, 3'b010, 7'b1100001, SFetch, 1'b0, 2'b00}; // BLT t
    tbl[12] = '{7'b1100011, 3'b101, 7'b0000000, 3'b010, 7'b0100001, SFetch, 1'b0, 2'b00}; // BGE n
    tbl[13] = '{7'b1100011, 3'b110, 7'b0000000, 3'b000, 7'b0100001, SFetch, 1'b0, 2'b00}; // BLTU n
    tbl[14] = '{7'b1100011, 3'b111, 7'b0000000, 3'b000, 7'b1100001, SFetch, 1'b0, 2'b00}; // BGEU t
    tbl[15] = '{7'b1101111, 3'b000, 7'b0000000, 3'b000, 7'b1101110, SWb,   1'b0, 2'b10}; // JAL
    tbl[16] = '{7'b1100111, 3'b000, 7'b0000000, 3'b000, 7'b1100110, SWb,   1'b0, 2'b10}; // JALR
    tbl[17] = '{7'b0110111, 3'b000, 7'b0000000, 3'b000, 7'b0010110, SWb,   1'b0, 2'b00}; // LUI
    tbl[18] = '{7'b0010111, 3'b000, 7'b0000000, 3'b000, 7'b0001110, SWb,   1'b0, 2'b00}; // AUIPC

    set_instr(7'b0110011, 3'b000, 7'b0, 3'b000);
    mem_ready = 1'b0;
    do_reset();

    // FETCH must hold while memory is not ready.
    step(); #1;
    chk("fetch wait", 32'({state, mem_req, ir_write, pc_write}), 32'({SFetch, 3'b100}));

    for (int i = 0; i < NVec; i++) begin
      run_vec(i, tbl[i]);
    end

    // LOAD with three MEM wait cycles: 8 cycles FETCH to FETCH.
    set_instr(7'b0000011, 3'b010, 7'b0, 3'b000);
    mem_ready = 1'b1;
    cyc = 0;
    step(); cyc++;
    step(); cyc++;
    step(); cyc++;
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      chk($sformatf("load wait %0d", k), 32'({state, mem_req, mem_we}), 32'({SMem, 2'b10}));
      step(); cyc++;
    end
    #1;
    chk("load wb", 32'({state, reg_write, wb_sel}), 32'({SWb, 3'b101}));
    for (int k = 0; k < 4 && state != SFetch; k++) begin
      step(); cyc++; #1;
    end
    chk("load cycle count", 32'(cyc), 32'd8);

    // Branch with undefined funct3 goes to TRAP from EXEC.
    set_instr(7'b1100011, 3'b010, 7'b0, 3'b000);
    step(); step(); #1;
    chk("bad branch exec pc_write", 32'({state, pc_write}), 32'({SExec, 1'b0}));
    step(); #1;
    chk("bad branch trap", 32'({state, trap}), 32'({STrap, 1'b1}));
    do_reset();

    // Illegal opcode: DECODE, then TRAP held until reset.
    set_instr(7'b1111111, 3'b000, 7'b0, 3'b000);
    mem_ready = 1'b1;
    step(); #1;
    chk("illegal decode", 32'(state), 32'(SDecode));
    for (int k = 0; k < 20; k++) begin
      step(); #1;
      chk($sformatf("trap hold %0d", k), 32'({state, trap, mem_req, pc_write, reg_write}),
          32'({STrap, 4'b1000}));
    end
    do_reset();

    // Reset dropped during a STORE's MEM wait.
    set_instr(7'b0100011, 3'b010, 7'b0, 3'b000);
    step(); step(); step();
    mem_ready = 1'b0;
    step(); #1;
    chk("store waiting", 32'({state, mem_req, mem_we}), 32'({SMem, 2'b11}));
    rst_n = 1'b0;
    #1;
    chk("reset mid handshake", 32'({state, mem_req, mem_we}), 32'({SStart, 2'b00}));
    #1;
    rst_n = 1'b1;
    step(); #1;
    chk("resume fetch", 32'({state, mem_req}), 32'({SFetch, 1'b1}));
    run_vec(0, tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
